// File: rtl/seven_segment_controller.sv
// Time-multiplexed driver for a bank of common-anode seven-segment digits.
// Scans one nibble of val_in per digit period. Anodes and cathodes are active-low.
// The value is captured once per frame so that a mid-frame change cannot tear the display.
// Optional build macro SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Digit 0 is never blanked.
module seven_segment_controller #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned COUNT_PERIOD = 100000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic                    en_in,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              cat_out
);

  localparam int unsigned CW = $clog2(COUNT_PERIOD);
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CountLast = CW'(COUNT_PERIOD - 1);
  localparam logic [DW-1:0] DigitLast = DW'(NUM_DIGITS - 1);

  logic [CW-1:0]           count_r, count_d;
  logic [DW-1:0]           digit_r, digit_d;
  logic [4*NUM_DIGITS-1:0] snap_r;
  logic [4*NUM_DIGITS-1:0] eff;
  logic                    frame_start;
  logic [NUM_DIGITS-1:0]   sel;
  logic [3:0]              nib;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [6:0]              cat_d;

  // Active-high segment pattern, bit 0 = seg a ... bit 6 = seg g.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  // At frame start, take val_in directly; otherwise use the held snapshot.
  always_comb begin
    frame_start = (count_r == '0) && (digit_r == '0);
    eff         = frame_start ? val_in : snap_r;
  end

  // Per-digit period counter and digit index, both wrapping.
  always_comb begin
    count_d = count_r + CW'(1);
    digit_d = digit_r;
    if (count_r == CountLast) begin
      count_d = '0;
      digit_d = (digit_r == DigitLast) ? '0 : digit_r + DW'(1);
    end
  end

  // Select the current digit: one-hot anode position and its nibble of eff.
  always_comb begin
    sel = '0;
    nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_r == DW'(i)) begin
        sel[i] = 1'b1;
        nib    = eff[4*i +: 4];
      end
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  zacc;

  // upper_zero[i] is set when nibbles i..top of eff are all zero. Digit 0 is never blanked.
  always_comb begin
    zacc       = 1'b1;
    upper_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zacc                           = zacc & (eff[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
      upper_zero[NUM_DIGITS-1-i] = zacc;
    end
    upper_zero[0] = 1'b0;
    lit           = en_in && ((sel & upper_zero) == '0);
  end
`else
  // All digits are shown, including leading zeros.
  always_comb begin
    lit = en_in;
  end
`endif

  // Next output values. The cathodes decode even while the anodes are blanked.
  always_comb begin
    an_d  = lit ? ~sel : '1;
    cat_d = ~seg_decode(nib);
  end

  // State and registered outputs. A synchronous reset aborts the current scan.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_r <= '0;
      digit_r <= '0;
      snap_r  <= '0;
      an_out  <= '1;
      cat_out <= 7'h7F;
    end else begin
      count_r <= count_d;
      digit_r <= digit_d;
      snap_r  <= eff;
      an_out  <= an_d;
      cat_out <= cat_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_controller.sv
// Self-checking bench for seven_segment_controller with NUM_DIGITS=4 and COUNT_PERIOD=4.
// Directed tables and sequences are combined with randomized traffic.
// The checks compare against a frame/position reference model.
module tb_seven_segment_controller;

  localparam int unsigned ND = 4;
  localparam int unsigned CP = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] val_in;
  logic        en_in;
  logic [3:0]  an_out;
  logic [6:0]  cat_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  seven_segment_controller #(
    .NUM_DIGITS  (ND),
    .COUNT_PERIOD(CP)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .val_in (val_in),
    .en_in  (en_in),
    .an_out (an_out),
    .cat_out(cat_out)
  );

  logic [6:0] seg_tab [16];

  // Reference model. m_k counts the edges since reset.
  // The position in the frame is m_k mod (CP*ND).
  int unsigned m_k;
  logic [15:0] m_frame;
  logic [3:0]  m_an;
  logic [6:0]  m_cat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compute the outputs expected after the coming edge from the inputs presented now.
  task automatic model_edge();
    int unsigned pos;
    int unsigned dig;
    logic [3:0]  n;
    if (rst_in) begin
      m_k     = 0;
      m_frame = 16'h0;
      m_an    = 4'hF;
      m_cat   = 7'h7F;
    end else begin
      pos = m_k % (CP * ND);
      if (pos == 0) m_frame = val_in;
      dig   = pos / CP;
      n     = m_frame[4*dig +: 4];
      m_cat = ~seg_tab[n];
      m_an  = 4'hF;
      if (en_in) m_an[dig] = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (dig > 0 && (m_frame >> (4 * dig)) == 16'h0) m_an = 4'hF;
`endif
      m_k++;
    end
  endtask

  // Advance one edge, sample 1 time unit later and check against the model.
  task automatic tick();
    model_edge();
    @(posedge clk_in);
    #1;
    chk("model_an", {28'h0, an_out}, {28'h0, m_an});
    chk("model_cat", {25'h0, cat_out}, {25'h0, m_cat});
  endtask

  task automatic do_reset(input logic [15:0] v);
    rst_in = 1'b1;
    val_in = v;
    en_in  = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  typedef struct {
    logic [15:0] val;
    logic        en;
    logic [3:0]  an;
    logic [6:0]  cat;
  } vec_t;

  vec_t tab [17];

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Scan table for edges 1..17 with val_in=12AF.
    for (int i = 0; i < 17; i++) begin
      tab[i].val = 16'h12AF;
      tab[i].en  = 1'b1;
      if (i < 4)       begin tab[i].an = 4'hE; tab[i].cat = 7'h0E; end
      else if (i < 8)  begin tab[i].an = 4'hD; tab[i].cat = 7'h08; end
      else if (i < 12) begin tab[i].an = 4'hB; tab[i].cat = 7'h24; end
      else if (i < 16) begin tab[i].an = 4'h7; tab[i].cat = 7'h79; end
      else             begin tab[i].an = 4'hE; tab[i].cat = 7'h0E; end
    end

    // Hold reset for three cycles.
    rst_in = 1'b1;
    val_in = 16'h12AF;
    en_in  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_an", {28'h0, an_out}, 32'hF);
      chk("reset_cat", {25'h0, cat_out}, 32'h7F);
    end
    rst_in = 1'b0;

    // Basic scan, edges 1..17.
`ifndef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    for (int i = 0; i < 17; i++) begin
      val_in = tab[i].val;
      en_in  = tab[i].en;
      tick();
      chk("scan_an", {28'h0, an_out}, {28'h0, tab[i].an});
      chk("scan_cat", {25'h0, cat_out}, {25'h0, tab[i].cat});
    end

    // Tearing: val_in drops to 0 after edge 6, which must not show until edge 17.
    do_reset(16'h12AF);
    for (int e = 1; e <= 24; e++) begin
      if (e == 7) val_in = 16'h0000;
      tick();
      if (e >= 7) begin
        chk("tear_cat", {25'h0, cat_out},
            (e <= 8) ? 32'h08 : (e <= 12) ? 32'h24 : (e <= 16) ? 32'h79 : 32'h40);
      end
    end

    // Enable: en_in low after edge 7, high again after edge 10.
    do_reset(16'h12AF);
    for (int e = 1; e <= 13; e++) begin
      if (e == 8)  en_in = 1'b0;
      if (e == 11) en_in = 1'b1;
      tick();
      if (e >= 8 && e <= 10) chk("en_off_an", {28'h0, an_out}, 32'hF);
      if (e == 8) chk("en_off_cat", {25'h0, cat_out}, 32'h08);
      if (e == 11 || e == 12) chk("en_back_an", {28'h0, an_out}, 32'hB);
      if (e == 13) chk("en_pos_an", {28'h0, an_out}, 32'h7);
    end

    // Reset asserted mid-scan after edge 10.
    do_reset(16'h12AF);
    for (int e = 1; e <= 10; e++) tick();
    rst_in = 1'b1;
    tick();
    chk("midrst_an", {28'h0, an_out}, 32'hF);
    chk("midrst_cat", {25'h0, cat_out}, 32'h7F);
    rst_in = 1'b0;
    tick();
    chk("restart_an", {28'h0, an_out}, 32'hE);
    chk("restart_cat", {25'h0, cat_out}, 32'h0E);
`else
    // Leading-zero blanking: 0030 lights digits 0 and 1 only.
    do_reset(16'h0030);
    for (int e = 1; e <= 16; e++) begin
      tick();
      chk("lzb_an", {28'h0, an_out}, (e <= 4) ? 32'hE : (e <= 8) ? 32'hD : 32'hF);
    end
    do_reset(16'h0000);
    for (int e = 1; e <= 16; e++) begin
      tick();
      chk("lzb0_an", {28'h0, an_out}, (e <= 4) ? 32'hE : 32'hF);
      chk("lzb0_cat", {25'h0, cat_out}, 32'h40);
    end
`endif

    // Randomized traffic checked by the model.
    do_reset(16'($urandom));
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) val_in = 16'($urandom);
      if ($urandom_range(7) == 0) val_in = 16'($urandom) & 16'h00FF;
      en_in  = ($urandom_range(9) != 0);
      rst_in = ($urandom_range(199) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
